step_pulse_gen: RTL and testbench
=================================

# step_pulse_gen

Per-axis step/direction pulse generator that sits directly downstream of the UART position-command parser. Accepts one signed position delta per control frame, spreads exactly |delta| step pulses evenly across the next frame, and drives the driver's DIR/STEP pins. One instance per motor axis; all instances share the frame tick derived from the 10 MHz clock.

## Interface
- DELTA_W, 8: width of signed delta (two's complement); max magnitude 2^(DELTA_W-1).
- FRAME_CYCLES, 4096: clocks between frame_tick pulses (4096 at 10 MHz ≈ 0.41 ms frame).
- PULSE_W, 10: STEP high time in clocks; must be < FRAME_CYCLES / 2^DELTA_W.
- DIR_SETUP, 8: min clocks from DIR change to STEP rise; must be ≤ FRAME_CYCLES / 2^DELTA_W.
- POS_W, 16: width of position counter.
- CLK_10MHZ  in  1  system clock.
- RST_N  in  1  synchronous reset, active-low.
- frame_tick  in  1  one-cycle frame strobe, every FRAME_CYCLES clocks.
- delta_pos  in  DELTA_W  signed step delta for next frame.
- delta_valid  in  1  one-cycle strobe qualifying delta_pos.
- dir  out  1  driver direction; 1 = positive delta.
- step  out  1  driver step pulse.
- busy  out  1  steps remaining in current frame.
- overrun  out  1  sticky: frame ended with steps undelivered.
- pos  out  POS_W  signed accumulated position (see Configuration).

## Operation
- Reset (RST_N=0 at a CLK_10MHZ edge): step=0, dir=0, busy=0, overrun=0, pos=0; pending and active registers cleared; pending_valid=0.
- Capture: delta_valid registers delta_pos into pending, sets pending_valid. A second delta_valid in the same frame overwrites (last wins).
- Frame start (frame_tick=1): if pending_valid, load remaining=|pending| (DELTA_W-bit unsigned, -2^(DELTA_W-1) maps to 2^(DELTA_W-1)), acc=FRAME_CYCLES/2, clear pending_valid; if pending nonzero, dir=sign (1 if positive). If !pending_valid or pending=0: remaining=0, dir holds.
- delta_valid and frame_tick in same cycle: the old pending is applied; new delta becomes pending for the following frame.
- Step scheduling (Bresenham): each clock with remaining>0 and not in pulse: acc += |d|; when acc ≥ FRAME_CYCLES, acc -= FRAME_CYCLES, assert step, decrement remaining. Step k (1-based) rises ceil((k-0.5)·FRAME_CYCLES/|d|) clocks after frame_tick.
- step stays high PULSE_W clocks, then low; accumulator continues advancing during pulse.
- Frame end: frame_tick arriving with remaining>0 sets overrun (sticky until reset), discards remaining; a pulse in progress completes its full PULSE_W.
- busy = (remaining != 0) || step.
- States: IDLE (remaining=0) → RUN (frame load, |d|>0) → IDLE (remaining hits 0 after last pulse) or RUN (new frame_tick reloads).

## Timing
- delta_valid to capture: 1 clock; capture to effect: next frame_tick.
- dir changes on the clock after frame_tick; first STEP rise ≥ FRAME_CYCLES/2^DELTA_W clocks later, satisfying DIR_SETUP.
- Min step period FRAME_CYCLES/2^(DELTA_W-1) (32 clocks default), duty ≤ 31%.
- All outputs registered; no combinational input→output path.

## Configuration
- STEP_POS_COUNTER_EN defined: pos += 1 (dir=1) or −= 1 (dir=0) on every step rising edge; wraps modulo 2^POS_W.
- Not defined: pos constant 0, counter logic absent.

## Test plan
- Reset then delta=+4, frame_tick at T0 → dir=1, 4 step rises at T0+512, +1536, +2560, +3584 (±1 clk), each 10 clocks wide; busy falls after last pulse; overrun=0.
- delta=-128 → dir=0, 128 pulses, first at T0+16, period 32, none after T0+4096.
- delta=+4, second frame_tick at T0+1000 → one pulse only, overrun=1 and remains 1 through later good frames until RST_N=0.
- No delta_valid in a frame, or delta=0 → zero pulses, dir unchanged, busy=0.
- RST_N=0 mid-pulse in a delta=+64 frame → next clock step=0, busy=0, dir=0, pos=0; no further pulses until new delta and frame_tick.
- With STEP_POS_COUNTER_EN: frames +4, -3, -128 → pos=4, 1, -127 (0xFF81); without macro pos=0 throughout.

Source files
------------

// File: rtl/step_pulse_gen.sv
// -----------------------------------------------------------------------------
// step_pulse_gen
//
// Per-axis step/direction pulse generator. One signed position delta is
// accepted per control frame. On the next frame_tick, exactly |delta| STEP
// pulses are spread evenly across that frame. A Bresenham accumulator makes
// the spacing even, and DIR is updated at the frame boundary.
//
// Optional feature: define STEP_POS_COUNTER_EN to build the signed position
// counter on `pos`. Without the macro, `pos` is tied to zero and no counter
// logic exists.
//
// Parameters
//   DELTA_W      width of the signed delta (two's complement)
//   FRAME_CYCLES clocks between frame_tick strobes
//   PULSE_W      STEP high time in clocks
//   DIR_SETUP    minimum clocks from a DIR change to a STEP rise
//   POS_W        width of the position counter
//
// Ports
//   CLK_10MHZ    in   system clock
//   RST_N        in   synchronous reset, active-low
//   frame_tick   in   one-cycle frame strobe
//   delta_pos    in   signed step delta for the next frame
//   delta_valid  in   one-cycle strobe qualifying delta_pos
//   dir          out  driver direction, 1 = positive delta
//   step         out  driver step pulse
//   busy         out  steps remaining in the frame, or a pulse in flight
//   overrun      out  sticky: a frame ended with steps undelivered
//   pos          out  signed accumulated position (zero without the macro)
// -----------------------------------------------------------------------------
module step_pulse_gen #(
   parameter int DELTA_W      = 8,
   parameter int FRAME_CYCLES = 4096,
   parameter int PULSE_W      = 10,
   parameter int DIR_SETUP    = 8,
   parameter int POS_W        = 16
) (
   input  logic                      CLK_10MHZ,
   input  logic                      RST_N,
   input  logic                      frame_tick,
   input  logic signed [DELTA_W-1:0] delta_pos,
   input  logic                      delta_valid,
   output logic                      dir,
   output logic                      step,
   output logic                      busy,
   output logic                      overrun,
   output logic signed [POS_W-1:0]   pos
);

   // The accumulator never exceeds FRAME_CYCLES + a few |d| increments.
   // Two extra bits give plenty of headroom.
   localparam int               ACC_W   = $clog2(FRAME_CYCLES) + 2;
   localparam int               PW_W    = $clog2(PULSE_W + 1);
   localparam logic [ACC_W-1:0] FRAME_C = ACC_W'(FRAME_CYCLES);
   localparam logic [ACC_W-1:0] HALF_C  = ACC_W'(FRAME_CYCLES / 2);
   localparam logic [PW_W-1:0]  PW_LAST = PW_W'(PULSE_W - 1);

   // Smallest gap between a frame start and the first step rise.
   // The pulse width and the DIR setup time must both fit inside it.
   localparam int SLOT = FRAME_CYCLES / (2 ** DELTA_W);

   generate
      if (PULSE_W >= SLOT || DIR_SETUP > SLOT || PULSE_W < 1) begin : g_cfg_check
         $error("step_pulse_gen: PULSE_W/DIR_SETUP do not fit the minimum step slot");
      end
   endgenerate

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Magnitude as an unsigned DELTA_W value.
   // The most negative delta maps to 2^(DELTA_W-1), which still fits.
   function automatic logic [DELTA_W-1:0] mag_of(input logic signed [DELTA_W-1:0] d);
      if (d[DELTA_W-1]) begin
         return unsigned'(-d);
      end
      return unsigned'(d);
   endfunction

   state_t                    state_q, state_d;
   logic signed [DELTA_W-1:0] pend_q, pend_d;
   logic                      pend_vld_q, pend_vld_d;
   logic [DELTA_W-1:0]        rem_q, rem_d;
   logic [DELTA_W-1:0]        mag_q, mag_d;
   logic [ACC_W-1:0]          acc_q, acc_d;
   logic                      dir_q, dir_d;
   logic                      step_q, step_d;
   logic [PW_W-1:0]           pw_cnt_q, pw_cnt_d;
   logic                      overrun_q, overrun_d;
   logic                      busy_q, busy_d;

   logic [ACC_W-1:0]          acc_sum;
   logic                      fire;

   always_ff @(posedge CLK_10MHZ) begin
      if (!RST_N) begin
         state_q    <= IDLE;
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
         rem_q      <= '0;
         mag_q      <= '0;
         acc_q      <= '0;
         dir_q      <= 1'b0;
         step_q     <= 1'b0;
         pw_cnt_q   <= '0;
         overrun_q  <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         rem_q      <= rem_d;
         mag_q      <= mag_d;
         acc_q      <= acc_d;
         dir_q      <= dir_d;
         step_q     <= step_d;
         pw_cnt_q   <= pw_cnt_d;
         overrun_q  <= overrun_d;
         busy_q     <= busy_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      rem_d      = rem_q;
      mag_d      = mag_q;
      acc_d      = acc_q;
      dir_d      = dir_q;
      step_d     = step_q;
      pw_cnt_d   = pw_cnt_q;
      overrun_d  = overrun_q;
      busy_d     = busy_q;
      fire       = 1'b0;
      acc_sum    = acc_q + {{(ACC_W - DELTA_W){1'b0}}, mag_q};

      // Capture stage.
      // A new delta always wins over the frame-start clear of pending_valid.
      // When both arrive in the same cycle, the frame start below uses the
      // old pending value, and the new delta waits for the following frame.
      if (delta_valid) begin
         pend_d     = delta_pos;
         pend_vld_d = 1'b1;
      end else if (frame_tick) begin
         pend_vld_d = 1'b0;
      end

      if (frame_tick) begin
         // Frame boundary.
         // Leftover steps are dropped and flagged.
         // A pulse already in flight is left to finish below.
         if (rem_q != '0) begin
            overrun_d = 1'b1;
         end
         rem_d = '0;
         if (pend_vld_q) begin
            // Starting at half a frame centres each step in its slot.
            acc_d = HALF_C;
            if (pend_q != '0) begin
               rem_d = mag_of(pend_q);
               mag_d = mag_of(pend_q);
               dir_d = ~pend_q[DELTA_W-1];
            end
         end
      end else if (state_q == RUN) begin
         // Bresenham scheduling stage.
         // The accumulator keeps advancing during a pulse.
         // A crossing reached while STEP is still high is taken on the first
         // clock after the pulse ends.
         acc_d = acc_sum;
         if (acc_sum >= FRAME_C && !step_q) begin
            fire  = 1'b1;
            acc_d = acc_sum - FRAME_C;
            rem_d = rem_q - DELTA_W'(1);
         end
      end

      // Pulse shaping stage: STEP is held high for exactly PULSE_W clocks.
      if (fire) begin
         step_d   = 1'b1;
         pw_cnt_d = PW_LAST;
      end else if (step_q) begin
         if (pw_cnt_q == '0) begin
            step_d = 1'b0;
         end else begin
            pw_cnt_d = pw_cnt_q - PW_W'(1);
         end
      end

      state_d = (rem_d != '0) ? RUN : IDLE;
      busy_d  = (rem_d != '0) || step_d;
   end

   assign dir     = dir_q;
   assign step    = step_q;
   assign busy    = busy_q;
   assign overrun = overrun_q;

`ifdef STEP_POS_COUNTER_EN
   logic signed [POS_W-1:0] pos_q, pos_d;

   // Position tracks every step rise and wraps modulo 2^POS_W.
   always_comb begin
      pos_d = pos_q;
      if (fire) begin
         pos_d = dir_q ? (pos_q + POS_W'(1)) : (pos_q - POS_W'(1));
      end
   end

   always_ff @(posedge CLK_10MHZ) begin
      if (!RST_N) begin
         pos_q <= '0;
      end else begin
         pos_q <= pos_d;
      end
   end

   assign pos = pos_q;
`else
   assign pos = '0;
`endif

endmodule

// File: tb/tb_step_pulse_gen.sv
// -----------------------------------------------------------------------------
// tb_step_pulse_gen
//
// Directed bench for step_pulse_gen with the default parameters
// (8-bit delta, 4096-clock frame, 10-clock pulse).
//
// Step rise times are counted from the negedge that follows the posedge which
// samples frame_tick. Expected rise k lands at ceil((k-0.5)*4096/|d|).
// Expected pos values follow STEP_POS_COUNTER_EN; without the macro they are 0.
// -----------------------------------------------------------------------------
module tb_step_pulse_gen;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              frame_tick = 1'b0;
   logic              delta_valid = 1'b0;
   logic signed [7:0] delta_pos = '0;
   logic              dir, step, busy, overrun;
   logic signed [15:0] pos;

   int n_tests = 0;
   int n_fail  = 0;
   int rise_q[$];
   int width_q[$];

   step_pulse_gen #(
      .DELTA_W     (8),
      .FRAME_CYCLES(4096),
      .PULSE_W     (10),
      .DIR_SETUP   (8),
      .POS_W       (16)
   ) dut (
      .CLK_10MHZ  (clk),
      .RST_N      (rst_n),
      .frame_tick (frame_tick),
      .delta_pos  (delta_pos),
      .delta_valid(delta_valid),
      .dir        (dir),
      .step       (step),
      .busy       (busy),
      .overrun    (overrun),
      .pos        (pos)
   );

   always #50 clk = ~clk;

   function automatic logic signed [15:0] pos_exp(input int v);
`ifdef STEP_POS_COUNTER_EN
      return 16'(v);
`else
      return 16'(v) & 16'h0000;
`endif
   endfunction

   function automatic int rise_at(input int k);
      if (k < rise_q.size()) return rise_q[k];
      return -1;
   endfunction

   task automatic send_delta(input int d);
      @(negedge clk);
      delta_pos   = 8'(d);
      delta_valid = 1'b1;
      @(negedge clk);
      delta_valid = 1'b0;
   endtask

   // Returns at the negedge right after the posedge that sampled the tick.
   task automatic pulse_tick();
      @(negedge clk);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
   endtask

   // Records step rise indices and pulse widths over n cycles.
   task automatic run_cycles(input int n);
      logic prev;
      int   w;
      prev = step;
      w    = 0;
      rise_q.delete();
      width_q.delete();
      for (int i = 1; i <= n; i++) begin
         @(negedge clk);
         if (step && !prev) rise_q.push_back(i);
         if (step) w++;
         else if (prev) begin
            width_q.push_back(w);
            w = 0;
         end
         prev = step;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_tests++; if (step !== 1'b0) begin n_fail++; $display("FAIL rst_step: got %b, expected 0", step); end
      n_tests++; if (dir !== 1'b0) begin n_fail++; $display("FAIL rst_dir: got %b, expected 0", dir); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b, expected 0", busy); end
      n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rst_overrun: got %b, expected 0", overrun); end
      n_tests++; if (pos !== 16'sd0) begin n_fail++; $display("FAIL rst_pos: got %0d, expected 0", pos); end
      rst_n = 1'b1;
   endtask

   task automatic test_plus4();
      int exp_r[4] = '{512, 1536, 2560, 3584};
      int bad;
      send_delta(4);
      pulse_tick();
      n_tests++; if (dir !== 1'b1) begin n_fail++; $display("FAIL p4_dir: got %b, expected 1", dir); end
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL p4_busy_start: got %b, expected 1", busy); end
      run_cycles(4095);
      n_tests++; if (rise_q.size() != 4) begin n_fail++; $display("FAIL p4_count: got %0d, expected 4", rise_q.size()); end
      for (int k = 0; k < 4; k++) begin
         n_tests++;
         if (rise_at(k) != exp_r[k]) begin
            n_fail++; $display("FAIL p4_rise%0d: got %0d, expected %0d", k + 1, rise_at(k), exp_r[k]);
         end
      end
      bad = 0;
      foreach (width_q[i]) if (width_q[i] != 10) bad++;
      n_tests++; if (bad != 0 || width_q.size() != 4) begin n_fail++; $display("FAIL p4_width: got %0d bad of %0d pulses, expected 0 bad of 4", bad, width_q.size()); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL p4_busy_end: got %b, expected 0", busy); end
      n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL p4_overrun: got %b, expected 0", overrun); end
      n_tests++; if (pos !== pos_exp(4)) begin n_fail++; $display("FAIL p4_pos: got %0d, expected %0d", pos, pos_exp(4)); end
   endtask

   task automatic test_no_delta();
      pulse_tick();
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL nod_busy: got %b, expected 0", busy); end
      run_cycles(4095);
      n_tests++; if (rise_q.size() != 0) begin n_fail++; $display("FAIL nod_count: got %0d, expected 0", rise_q.size()); end
      n_tests++; if (dir !== 1'b1) begin n_fail++; $display("FAIL nod_dir: got %b, expected 1", dir); end
      send_delta(0);
      pulse_tick();
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy: got %b, expected 0", busy); end
      run_cycles(4095);
      n_tests++; if (rise_q.size() != 0) begin n_fail++; $display("FAIL zero_count: got %0d, expected 0", rise_q.size()); end
      n_tests++; if (dir !== 1'b1) begin n_fail++; $display("FAIL zero_dir: got %b, expected 1", dir); end
      n_tests++; if (pos !== pos_exp(4)) begin n_fail++; $display("FAIL zero_pos: got %0d, expected %0d", pos, pos_exp(4)); end
   endtask

   task automatic test_neg3();
      int exp_r[3] = '{683, 2048, 3414};
      send_delta(-3);
      pulse_tick();
      n_tests++; if (dir !== 1'b0) begin n_fail++; $display("FAIL n3_dir: got %b, expected 0", dir); end
      run_cycles(4095);
      n_tests++; if (rise_q.size() != 3) begin n_fail++; $display("FAIL n3_count: got %0d, expected 3", rise_q.size()); end
      for (int k = 0; k < 3; k++) begin
         n_tests++;
         if (rise_at(k) != exp_r[k]) begin
            n_fail++; $display("FAIL n3_rise%0d: got %0d, expected %0d", k + 1, rise_at(k), exp_r[k]);
         end
      end
      n_tests++; if (pos !== pos_exp(1)) begin n_fail++; $display("FAIL n3_pos: got %0d, expected %0d", pos, pos_exp(1)); end
   endtask

   task automatic test_neg128();
      int bad;
      send_delta(-128);
      pulse_tick();
      n_tests++; if (dir !== 1'b0) begin n_fail++; $display("FAIL n128_dir: got %b, expected 0", dir); end
      run_cycles(4095);
      n_tests++; if (rise_q.size() != 128) begin n_fail++; $display("FAIL n128_count: got %0d, expected 128", rise_q.size()); end
      n_tests++; if (rise_at(0) != 16) begin n_fail++; $display("FAIL n128_first: got %0d, expected 16", rise_at(0)); end
      bad = 0;
      for (int i = 1; i < rise_q.size(); i++) if (rise_q[i] - rise_q[i-1] != 32) bad++;
      n_tests++; if (bad != 0) begin n_fail++; $display("FAIL n128_period: got %0d gaps not 32, expected 0", bad); end
      n_tests++; if (rise_at(127) != 4080) begin n_fail++; $display("FAIL n128_last: got %0d, expected 4080", rise_at(127)); end
      bad = 0;
      foreach (width_q[i]) if (width_q[i] != 10) bad++;
      n_tests++; if (bad != 0 || width_q.size() != 128) begin n_fail++; $display("FAIL n128_width: got %0d bad of %0d pulses, expected 0 bad of 128", bad, width_q.size()); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL n128_busy: got %b, expected 0", busy); end
      n_tests++; if (pos !== pos_exp(-127)) begin n_fail++; $display("FAIL n128_pos: got %0d, expected %0d", pos, pos_exp(-127)); end
   endtask

   // Last delta in a frame wins, and a delta coinciding with the tick is
   // deferred to the following frame.
   task automatic test_back_to_back();
      send_delta(5);
      send_delta(2);
      @(negedge clk);
      frame_tick  = 1'b1;
      delta_pos   = 8'sd8;
      delta_valid = 1'b1;
      @(negedge clk);
      frame_tick  = 1'b0;
      delta_valid = 1'b0;
      n_tests++; if (dir !== 1'b1) begin n_fail++; $display("FAIL b2b_dir: got %b, expected 1", dir); end
      run_cycles(4095);
      n_tests++; if (rise_q.size() != 2) begin n_fail++; $display("FAIL b2b_count1: got %0d, expected 2", rise_q.size()); end
      n_tests++; if (rise_at(0) != 1024) begin n_fail++; $display("FAIL b2b_rise1: got %0d, expected 1024", rise_at(0)); end
      n_tests++; if (rise_at(1) != 3072) begin n_fail++; $display("FAIL b2b_rise2: got %0d, expected 3072", rise_at(1)); end
      n_tests++; if (pos !== pos_exp(-125)) begin n_fail++; $display("FAIL b2b_pos1: got %0d, expected %0d", pos, pos_exp(-125)); end
      pulse_tick();
      run_cycles(4095);
      n_tests++; if (rise_q.size() != 8) begin n_fail++; $display("FAIL b2b_count2: got %0d, expected 8", rise_q.size()); end
      n_tests++; if (rise_at(0) != 256) begin n_fail++; $display("FAIL b2b_first8: got %0d, expected 256", rise_at(0)); end
      n_tests++; if (rise_at(7) != 3840) begin n_fail++; $display("FAIL b2b_last8: got %0d, expected 3840", rise_at(7)); end
      n_tests++; if (pos !== pos_exp(-117)) begin n_fail++; $display("FAIL b2b_pos2: got %0d, expected %0d", pos, pos_exp(-117)); end
   endtask

   task automatic test_overrun();
      send_delta(4);
      pulse_tick();
      run_cycles(998);
      n_tests++; if (rise_q.size() != 1) begin n_fail++; $display("FAIL ovr_count: got %0d, expected 1", rise_q.size()); end
      n_tests++; if (rise_at(0) != 512) begin n_fail++; $display("FAIL ovr_rise: got %0d, expected 512", rise_at(0)); end
      n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_before: got %b, expected 0", overrun); end
      pulse_tick();
      n_tests++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b, expected 1", overrun); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ovr_busy: got %b, expected 0", busy); end
      n_tests++; if (pos !== pos_exp(-116)) begin n_fail++; $display("FAIL ovr_pos: got %0d, expected %0d", pos, pos_exp(-116)); end
      send_delta(1);
      pulse_tick();
      run_cycles(4095);
      n_tests++; if (rise_at(0) != 2048 || rise_q.size() != 1) begin n_fail++; $display("FAIL ovr_good_rise: got %0d (count %0d), expected 2048 (count 1)", rise_at(0), rise_q.size()); end
      n_tests++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b, expected 1", overrun); end
      n_tests++; if (pos !== pos_exp(-115)) begin n_fail++; $display("FAIL ovr_pos2: got %0d, expected %0d", pos, pos_exp(-115)); end
   endtask

   task automatic test_reset_mid();
      send_delta(64);
      pulse_tick();
      run_cycles(34);
      n_tests++; if (rise_at(0) != 32) begin n_fail++; $display("FAIL rm_rise: got %0d, expected 32", rise_at(0)); end
      n_tests++; if (step !== 1'b1) begin n_fail++; $display("FAIL rm_step_high: got %b, expected 1", step); end
      rst_n = 1'b0;
      @(negedge clk);
      n_tests++; if (step !== 1'b0) begin n_fail++; $display("FAIL rm_step: got %b, expected 0", step); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy: got %b, expected 0", busy); end
      n_tests++; if (dir !== 1'b0) begin n_fail++; $display("FAIL rm_dir: got %b, expected 0", dir); end
      n_tests++; if (pos !== 16'sd0) begin n_fail++; $display("FAIL rm_pos: got %0d, expected 0", pos); end
      n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rm_overrun: got %b, expected 0", overrun); end
      rst_n = 1'b1;
      pulse_tick();
      run_cycles(4095);
      n_tests++; if (rise_q.size() != 0) begin n_fail++; $display("FAIL rm_after_count: got %0d, expected 0", rise_q.size()); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_after_busy: got %b, expected 0", busy); end
   endtask

   initial begin
      test_reset();
      test_plus4();
      test_no_delta();
      test_neg3();
      test_neg128();
      test_back_to_back();
      test_overrun();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
